// File: rtl/sr_flag_bank_ctrl_if.sv
// Request/response and latch-bank signals of the SR flag bank controller.
// The controller uses the slave modport; requesters and the latch bank use master.
interface sr_flag_bank_ctrl_if #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8,
    parameter int IW    = 3
) ();
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    op;
    logic [NREQ*IW-1:0] idx;
    logic [NREQ-1:0]    ack;
    logic               err;
    logic               busy;
    logic               init_done;
    logic [NFLAG-1:0]   sbar;
    logic [NFLAG-1:0]   rbar;
    logic [NFLAG-1:0]   q_fb;

    modport slave (
        input  req, op, idx, q_fb,
        output ack, err, busy, init_done, sbar, rbar
    );

    modport master (
        output req, op, idx, q_fb,
        input  ack, err, busy, init_done, sbar, rbar
    );
endinterface

// File: rtl/sr_flag_bank_ctrl.sv
// Round-robin arbiter and pulse sequencer for a bank of NAND SR latches.
// Drives one active-low line at a time, then verifies the latch feedback.
module sr_flag_bank_ctrl #(
    parameter int NREQ    = 4,
    parameter int NFLAG   = 8,
    parameter int IW      = 3,
    parameter int PULSE   = 2,
    parameter int RECOVER = 1
) (
    input  logic              clk,
    input  logic              reset,
    sr_flag_bank_ctrl_if.slave bus
);
    localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CMAX = (PULSE > RECOVER) ? PULSE : RECOVER;
    localparam int CW   = $clog2(CMAX + 1);

    // state    | meaning
    // INIT     | clear-all pulse on every rbar line
    // INIT_REC | recovery gap after clear-all
    // IDLE     | arbitrate pending requests
    // DRIVE    | one sbar or rbar line held low
    // RECOV    | all lines high before feedback check
    // CHECK    | ack the granted requester, flag error
    typedef enum logic [2:0] {INIT, INIT_REC, IDLE, DRIVE, RECOV, CHECK} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [GW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]    gnt_q, gnt_d;
    logic             op_q, op_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             oor_q, oor_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             init_done_q, init_done_d;
    logic [NFLAG-1:0] sbar_q, sbar_d;
    logic [NFLAG-1:0] rbar_q, rbar_d;

    logic             found;
    logic [GW-1:0]    g;
    logic [GW-1:0]    j;
    logic [IW-1:0]    idx_sel;
    logic             q_sel;
    logic             drive;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        op_d        = op_q;
        idx_d       = idx_q;
        oor_d       = oor_q;
        ack_d       = '0;
        err_d       = 1'b0;
        init_done_d = init_done_q;
        sbar_d      = '1;
        rbar_d      = '1;
        drive       = 1'b0;
        found       = 1'b0;
        g           = rr_ptr_q;
        j           = rr_ptr_q;
        idx_sel     = '0;
        q_sel       = 1'b0;

        // first pending request at or after rr_ptr wins
        for (int i = 0; i < NREQ; i++) begin
            j = GW'((int'(rr_ptr_q) + i) % NREQ);
            if (!found && bus.req[j]) begin
                found = 1'b1;
                g     = j;
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (g == GW'(k)) idx_sel = bus.idx[k*IW +: IW];
        end
        for (int i = 0; i < NFLAG; i++) begin
            if (idx_q == IW'(i)) q_sel = bus.q_fb[i];
        end

        unique case (state_q)
            INIT: begin
                if (cnt_q == CW'(PULSE)) begin
                    state_d = INIT_REC;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d  = cnt_q + CW'(1);
                    rbar_d = '0;
                end
            end
            INIT_REC: begin
                if (cnt_q == CW'(RECOVER)) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    init_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            IDLE: begin
                if (found) begin
                    gnt_d    = g;
                    op_d     = bus.op[g];
                    idx_d    = idx_sel;
                    rr_ptr_d = GW'((int'(g) + 1) % NREQ);
                    oor_d    = int'(idx_sel) >= NFLAG;
                    if (oor_d) begin
                        state_d  = CHECK;
                        ack_d[g] = 1'b1;
                        err_d    = 1'b1;
                    end else begin
                        state_d = DRIVE;
                        cnt_d   = CW'(1);
                        drive   = 1'b1;
                    end
                end
            end
            DRIVE: begin
                if (cnt_q == CW'(PULSE)) begin
                    state_d = RECOV;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    drive = 1'b1;
                end
            end
            RECOV: begin
                if (cnt_q == CW'(RECOVER)) begin
                    state_d      = CHECK;
                    cnt_d        = '0;
                    ack_d[gnt_q] = 1'b1;
                    err_d        = oor_q || (q_sel != op_q);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            CHECK:   state_d = IDLE;
            default: state_d = INIT;
        endcase

        // only one line of one polarity ever goes low outside INIT
        for (int i = 0; i < NFLAG; i++) begin
            if (drive && idx_d == IW'(i)) begin
                if (op_d) sbar_d[i] = 1'b0;
                else      rbar_d[i] = 1'b0;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            op_q        <= 1'b0;
            idx_q       <= '0;
            oor_q       <= 1'b0;
            ack_q       <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b1;
            init_done_q <= 1'b0;
            sbar_q      <= '1;
            rbar_q      <= '1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            oor_q       <= oor_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            init_done_q <= init_done_d;
            sbar_q      <= sbar_d;
            rbar_q      <= rbar_d;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;
    assign bus.init_done = init_done_q;
    assign bus.sbar      = sbar_q;
    assign bus.rbar      = rbar_q;
endmodule

// File: doc/sr_flag_bank_ctrl.md
Name: sr_flag_bank_ctrl

Overview:
- Controller and arbiter for a bank of NFLAG cross-coupled NAND set/reset latches. Each latch has active-low Sbar/Rbar inputs.
- Accepts set/clear requests from NREQ requesters, grants them round-robin, and drives one latch at a time with a timed active-low pulse followed by a recovery gap.
- Never asserts Sbar and Rbar low together. Checks latch Q feedback after every operation.
- Sits between software-visible flag logic and the latch bank. Performs a clear-all initialisation after reset.

Parameters:
- NREQ, 4, number of requesters
- NFLAG, 8, number of latches in the bank
- IW, 3, index width per requester (must satisfy 2**IW >= NFLAG)
- PULSE, 2, cycles an Sbar/Rbar line is held low (>=1)
- RECOVER, 1, cycles with all lines high after a pulse (>=1)

Ports:
- clk, input, 1, system clock, rising edge
- reset, input, 1, synchronous active-high reset
- req, input, NREQ, per-requester request, held until ack
- op, input, NREQ, per-requester operation: 1=set, 0=clear
- idx, input, NREQ*IW, per-requester latch index; requester k uses bits [k*IW +: IW]
- ack, output, NREQ, one-cycle completion pulse to the granted requester
- err, output, 1, one-cycle pulse coincident with ack on failure
- busy, output, 1, high whenever state != IDLE
- init_done, output, 1, high once the post-reset clear-all completes
- sbar, output, NFLAG, active-low set lines to the latch bank
- rbar, output, NFLAG, active-low reset lines to the latch bank
- q_fb, input, NFLAG, latch Q outputs, already synchronised to clk

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset). All outputs are registered.
- While reset=1: sbar=all 1, rbar=all 1, ack=0, err=0, busy=1, init_done=0, rr_ptr=0, state=INIT, counter=0.
- Reset takes effect at any point, including mid-pulse. Lines return high on the next edge and no ack is issued.
- INIT: rbar=all 0 for PULSE cycles, then all lines high for RECOVER cycles, then IDLE with init_done=1. init_done stays 1 until the next reset. Requests are ignored during INIT.
- IDLE arbitration:
  - Scan req starting at rr_ptr and grant the first set bit g.
  - Capture op[g], idx[g] and g.
  - Set rr_ptr <= (g+1) mod NREQ.
- IDLE transitions:
  - No request: stay in IDLE.
  - Captured idx < NFLAG: go to DRIVE.
  - Captured idx >= NFLAG: go directly to CHECK. No line is pulsed; err will fire.
- DRIVE: for PULSE cycles, drive sbar[idx]=0 if op=1, else rbar[idx]=0. All other lines stay 1. Then go to RECOVER.
- RECOVER: all lines 1 for RECOVER cycles, then go to CHECK.
- CHECK (1 cycle):
  - ack[g]=1.
  - err=1 if the index was out of range, or if q_fb[idx] != op.
  - Next state is IDLE.
- Invariants:
  - sbar[i] and rbar[i] are never both 0 for any i.
  - At most one line in sbar/rbar combined is low outside INIT.
  - At most one ack bit is high per cycle.
- Latency: a request sampled in IDLE at edge t produces:
  - DRIVE in cycles t+1 .. t+PULSE
  - RECOVER in cycles t+PULSE+1 .. t+PULSE+RECOVER
  - ack at cycle t+PULSE+RECOVER+1
  - IDLE again at the following cycle
- With defaults, ack arrives 4 cycles after grant, giving one operation per 5 cycles.
- If a requester drops req after grant, the operation still completes and ack is still pulsed.
- A requester may keep req high through ack to request again. Round-robin ordering gives other pending requesters priority first.
- op/idx changes after grant have no effect on the in-flight operation.

Test Plan:
- Reset, then release; model latches from sbar/rbar -> rbar=8'h00 for 2 cycles, all lines high 1 cycle, init_done=1, all q_fb=0, busy=0.
- req[0]=1, op=1, idx=5 -> sbar=8'hDF for 2 cycles, rbar=8'hFF throughout, ack[0]=1 at grant+4, err=0, q_fb[5]=1.
- req=4'b1111 held (ops alternate set/clear, distinct idx) -> ack order 0,1,2,3,0,... one per 5 cycles; a sbar/rbar both-low check never fires.
- req[2]=1, idx=3'b111 with NFLAG=6 -> no line pulsed, ack[2]=1 and err=1 one cycle after grant.
- Force q_fb[1]=0 during a set of idx=1 -> ack with err=1; next request proceeds normally.
- Assert reset during the second DRIVE cycle -> next edge all lines 1, ack=0, INIT re-runs, init_done=0 until INIT completes.
